conv3x3_mac_unit: RTL and testbench

- Downstream consumer of the 3x3 filter storage memory.
- Captures the 72-bit packed filter word into a local weight register.
- Accepts 72-bit 3x3 activation windows over a valid/ready handshake.
- Computes the signed 9-tap dot product serially, one tap per cycle, and presents the accumulated result over a valid/ready handshake to the next stage of the convolution datapath.

---
 rtl/conv3x3_mac_unit.sv | 140 ++++++++++++++
 tb/tb_conv3x3_mac_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac_unit.sv
// Serial 3x3 signed dot-product unit: one weight/activation tap per cycle, valid/ready in and out.
// Optional build macro CONV3X3_RELU_EN clamps negative results to zero on the way out.
module conv3x3_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9*DATA_W-1:0]   filter_in,
    input  logic                  filter_load,
    output logic                  load_err,
    input  logic [9*DATA_W-1:0]   win_in,
    input  logic                  win_valid,
    output logic                  win_ready,
    output logic [ACC_W-1:0]      res_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                    state_q, state_d;
    logic [9*DATA_W-1:0]       wts_q, wts_d;
    logic [9*DATA_W-1:0]       win_q, win_d;
    logic                      wts_loaded_q, wts_loaded_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [3:0]                tap_q, tap_d;
    logic [ACC_W-1:0]          res_q, res_d;
    logic                      res_valid_q, res_valid_d;
    logic                      busy_q, busy_d;
    logic                      load_err_q, load_err_d;
    logic                      win_ready_q, win_ready_d;

    logic signed [DATA_W-1:0]   w_tap, a_tap;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           sum;

    // Tap 0 lives in the most significant byte of both packed words.
    always_comb begin
        w_tap = '0;
        a_tap = '0;
        for (int t = 0; t < 9; t++) begin
            if (tap_q == 4'(t)) begin
                w_tap = wts_q[(8-t)*DATA_W +: DATA_W];
                a_tap = win_q[(8-t)*DATA_W +: DATA_W];
            end
        end
        prod = w_tap * a_tap;
        sum  = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

    always_comb begin
        state_d      = state_q;
        wts_d        = wts_q;
        win_d        = win_q;
        wts_loaded_d = wts_loaded_q;
        acc_d        = acc_q;
        tap_d        = tap_q;
        res_d        = res_q;
        load_err_d   = 1'b0;

        if (filter_load) begin
            if (state_q != MAC) begin
                wts_d        = filter_in;
                wts_loaded_d = 1'b1;
            end else begin
                load_err_d   = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (win_valid && win_ready_q) begin
                    win_d   = win_in;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'd8) begin
`ifdef CONV3X3_RELU_EN
                    res_d = sum[ACC_W-1] ? '0 : sum;
`else
                    res_d = sum;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d == MAC);
        win_ready_d = (state_d == IDLE) && wts_loaded_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wts_q        <= '0;
            win_q        <= '0;
            wts_loaded_q <= 1'b0;
            acc_q        <= '0;
            tap_q        <= '0;
            res_q        <= '0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            load_err_q   <= 1'b0;
            win_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wts_q        <= wts_d;
            win_q        <= win_d;
            wts_loaded_q <= wts_loaded_d;
            acc_q        <= acc_d;
            tap_q        <= tap_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            load_err_q   <= load_err_d;
            win_ready_q  <= win_ready_d;
        end
    end

    assign res_out   = res_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign load_err  = load_err_q;
    assign win_ready = win_ready_q;

endmodule

// File: tb/tb_conv3x3_mac_unit.sv
// Self-checking bench for conv3x3_mac_unit against an arithmetic dot-product model.
module tb_conv3x3_mac_unit;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  logic              clk;
  logic              reset;
  logic [71:0]       filter_in;
  logic              filter_load;
  logic              load_err;
  logic [71:0]       win_in;
  logic              win_valid;
  logic              win_ready;
  logic [ACC_W-1:0]  res_out;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  int errors = 0;
  int checks = 0;

  conv3x3_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset),
    .filter_in(filter_in), .filter_load(filter_load), .load_err(load_err),
    .win_in(win_in), .win_valid(win_valid), .win_ready(win_ready),
    .res_out(res_out), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain signed sum of nine byte products
  function automatic logic [ACC_W-1:0] ref_dot(input logic [71:0] w, input logic [71:0] a);
    int s;
    int wi;
    int ai;
    s = 0;
    for (int t = 0; t < 9; t++) begin
      wi = $signed(w[(8-t)*8 +: 8]);
      ai = $signed(a[(8-t)*8 +: 8]);
      s = s + wi * ai;
    end
`ifdef CONV3X3_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [71:0] rand_word();
    logic [71:0] r;
    for (int b = 0; b < 9; b++) begin
      case ($urandom_range(0, 4))
        0: r[b*8 +: 8] = 8'h80;
        1: r[b*8 +: 8] = 8'h7F;
        2: r[b*8 +: 8] = 8'hFF;
        default: r[b*8 +: 8] = 8'($urandom());
      endcase
    end
    return r;
  endfunction

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic load_filter(input logic [71:0] f);
    filter_in = f;
    filter_load = 1'b1;
    @(posedge clk); #1;
    filter_load = 1'b0;
  endtask

  task automatic start_window(input logic [71:0] a, output bit ok);
    ok = 1'b0;
    win_in = a;
    win_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (win_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    win_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    filter_in = '0; filter_load = 1'b0;
    win_in = '0; win_valid = 1'b0; res_ready = 1'b0;
    #1;
    checks++;
    if ({res_out, res_valid, win_ready, busy, load_err} !== {{ACC_W{1'b0}}, 4'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h rv=%b wr=%b busy=%b le=%b, want all 0",
               res_out, res_valid, win_ready, busy, load_err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    win_in = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    win_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (win_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_weights_holdoff: cycle %0d wr=%b rv=%b busy=%b, want 0 0 0",
                 i, win_ready, res_valid, busy);
      end
    end
    @(posedge clk); #1;
    win_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [71:0] w;
    logic [71:0] a;
    bit ok;
    int lat;
    w = {9{8'h01}};
    a = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    load_filter(w);
    start_window(a, ok);
    checks++;
    if (!ok || busy !== 1'b1 || win_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: ok=%b busy=%b wr=%b, want 1 1 0", ok, busy, win_ready);
    end
    wait_result(lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 9", lat);
    end
    checks++;
    if (res_out !== ref_dot(w, a) || res_out !== 20'd45) begin
      errors++;
      $display("FAIL basic_result: got %0d, want 45", $signed(res_out));
    end
    release_result();
    checks++;
    if (res_valid !== 1'b0 || win_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handoff: rv=%b wr=%b, want 0 1", res_valid, win_ready);
    end
  endtask

  task automatic test_corners();
    logic [71:0] ws[3];
    logic [71:0] as[3];
    bit ok;
    int lat;
    ws[0] = {9{8'hFF}}; as[0] = {9{8'h7F}};
    ws[1] = {9{8'h80}}; as[1] = {9{8'h80}};
    ws[2] = {8'd1, 8'hFE, 8'd3, 8'hFC, 8'd5, 8'hFA, 8'd7, 8'hF8, 8'd9}; as[2] = {9{8'h02}};
    for (int k = 0; k < 3; k++) begin
      load_filter(ws[k]);
      start_window(as[k], ok);
      wait_result(lat);
      checks++;
      if (!ok || lat !== 9 || res_out !== ref_dot(ws[k], as[k])) begin
        errors++;
        $display("FAIL corner_%0d: ok=%b lat=%0d got %h, want %h", k, ok, lat,
                 res_out, ref_dot(ws[k], as[k]));
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    logic [71:0] w;
    logic [71:0] a;
    logic [71:0] a2;
    logic [ACC_W-1:0] held;
    bit ok;
    int lat;
    w = rand_word(); a = rand_word(); a2 = rand_word();
    load_filter(w);
    start_window(a, ok);
    wait_result(lat);
    held = res_out;
    checks++;
    if (held !== ref_dot(w, a)) begin
      errors++;
      $display("FAIL hold_result: got %h, want %h", held, ref_dot(w, a));
    end
    win_in = a2;
    win_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_out !== held || res_valid !== 1'b1 || win_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d res=%h rv=%b wr=%b, want %h 1 0",
                 i, res_out, res_valid, win_ready, held);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || win_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: rv=%b wr=%b busy=%b, want 0 1 0", res_valid, win_ready, busy);
    end
    @(posedge clk); #1;
    win_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_accept: busy=%b, want 1", busy);
    end
    wait_result(lat);
    checks++;
    if (lat !== 9 || res_out !== ref_dot(w, a2)) begin
      errors++;
      $display("FAIL hold_next_result: lat=%0d got %h, want 9 %h", lat, res_out, ref_dot(w, a2));
    end
    release_result();
  endtask

  task automatic test_load_during_mac();
    logic [71:0] w_old;
    logic [71:0] a;
    bit ok;
    int lat;
    w_old = {9{8'h01}}; a = {9{8'h01}};
    load_filter(w_old);
    start_window(a, ok);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    filter_in = {9{8'h02}};
    filter_load = 1'b1;
    @(posedge clk); #1;
    filter_load = 1'b0;
    checks++;
    if (load_err !== 1'b1) begin
      errors++;
      $display("FAIL load_err_pulse: got %b, want 1", load_err);
    end
    @(posedge clk); #1;
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err_single: got %b, want 0", load_err);
    end
    wait_result(lat);
    checks++;
    if (lat !== 4 || res_out !== ref_dot(w_old, a)) begin
      errors++;
      $display("FAIL load_mac_result: lat=%0d got %0d, want 4 9", lat, $signed(res_out));
    end
    release_result();
    start_window(a, ok);
    wait_result(lat);
    checks++;
    if (!ok || res_out !== ref_dot(w_old, a)) begin
      errors++;
      $display("FAIL load_mac_old_wts: got %0d, want 9", $signed(res_out));
    end
    release_result();
  endtask

  task automatic test_load_on_accept();
    logic [71:0] w_a;
    logic [71:0] w_b;
    logic [71:0] w_c;
    logic [71:0] a;
    logic [ACC_W-1:0] held;
    bit ok;
    int lat;
    w_a = rand_word(); w_b = rand_word(); w_c = rand_word(); a = rand_word();
    load_filter(w_a);
    filter_in = w_b; filter_load = 1'b1;
    win_in = a; win_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (win_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_ready: got %b, want 1", win_ready);
    end
    @(posedge clk); #1;
    filter_load = 1'b0; win_valid = 1'b0;
    wait_result(lat);
    checks++;
    if (lat !== 9 || res_out !== ref_dot(w_b, a)) begin
      errors++;
      $display("FAIL same_edge_result: lat=%0d got %h, want 9 %h", lat, res_out, ref_dot(w_b, a));
    end
    held = res_out;
    load_filter(w_c);
    checks++;
    if (res_out !== held || res_valid !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL done_load: res=%h rv=%b le=%b, want %h 1 0", res_out, res_valid, load_err, held);
    end
    release_result();
    start_window(a, ok);
    wait_result(lat);
    checks++;
    if (!ok || res_out !== ref_dot(w_c, a)) begin
      errors++;
      $display("FAIL done_load_used: got %h, want %h", res_out, ref_dot(w_c, a));
    end
    release_result();
  endtask

  task automatic test_reset_mid_mac();
    logic [71:0] w;
    logic [71:0] a;
    bit ok;
    int lat;
    w = rand_word(); a = rand_word();
    load_filter(w);
    start_window(a, ok);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({res_out, res_valid, win_ready, busy, load_err} !== {{ACC_W{1'b0}}, 4'b0}) begin
      errors++;
      $display("FAIL reset_mid_mac: res=%h rv=%b wr=%b busy=%b le=%b, want all 0",
               res_out, res_valid, win_ready, busy, load_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    win_in = a; win_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (win_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_wts_cleared: cycle %0d wr=%b busy=%b, want 0 0", i, win_ready, busy);
      end
    end
    @(posedge clk); #1;
    win_valid = 1'b0;
    load_filter(w);
    start_window(a, ok);
    wait_result(lat);
    checks++;
    if (!ok || lat !== 9 || res_out !== ref_dot(w, a)) begin
      errors++;
      $display("FAIL reset_recover: ok=%b lat=%0d got %h, want %h", ok, lat, res_out, ref_dot(w, a));
    end
    release_result();
  endtask

  task automatic test_random();
    logic [71:0] w;
    logic [71:0] a;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] exp;
    bit ok;
    int lat;
    w = rand_word();
    load_filter(w);
    for (int j = 0; j < 25; j++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = rand_word();
        load_filter(w);
      end
      a = rand_word();
      exp_q.push_back(ref_dot(w, a));
      start_window(a, ok);
      wait_result(lat);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || lat !== 9 || res_out !== exp) begin
        errors++;
        $display("FAIL random_%0d: ok=%b lat=%0d got %h, want %h", j, ok, lat, res_out, exp);
      end
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        @(posedge clk); #1;
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_hold();
    test_load_during_mac();
    test_load_on_accept();
    test_reset_mid_mac();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
